fall_alarm_annunciator: RTL and testbench
=========================================

// Module: fall_alarm_annunciator
// PURPOSE
//  Caregiver-side consumer of fall_detection_system.alarm. Latches each alarm event,
//  drives LED and buzzer cadence, escalates to the pager via req/ack handshake if
//  unacknowledged, and counts events. Sits at the nurse station, 1 MHz clk domain.
// PARAMETERS
//  TICKS_PER_MS  1000  clk cycles per 1 ms tick
//  BEEP_ON_MS    500   buzzer on-phase length in ALERT (ms)
//  BEEP_OFF_MS   500   buzzer off-phase length in ALERT (ms)
//  ESCALATE_MS   60000 ms in ALERT without ack before escalation
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  synchronous, active-low reset
//  alarm          in   1  level from fall_detection_system
//  caregiver_ack  in   1  caregiver button, rising-edge acts
//  pager_ack      in   1  pager link accepted request
//  buzzer         out  1  audible output
//  alarm_led      out  1  visual alarm indicator
//  pager_req      out  1  page request, held until pager_ack
//  event_count    out  8  alarm events seen, saturating
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE; buzzer, alarm_led, pager_req=0;
//    event_count=0; all counters and input flops=0. Overrides any state.
//  - alarm, caregiver_ack, pager_ack registered once (alarm_q, ack_q, pack_q).
//    Edges are detected on the registered copies vs. their previous values.
//  - State and all outputs are registered on the same edge. An input high before
//    edge k gives its effect at edge k+1 (2-edge latency).
//  - ms tick: prescaler 0..TICKS_PER_MS-1, cleared on ALERT entry, tick on wrap.
//  - IDLE: outputs 0. alarm_q rise -> ALERT; event_count+1 (holds at 255);
//    prescaler, cadence, and escalation counters cleared.
//  - ALERT: alarm_led=1. buzzer=1 for BEEP_ON_MS, 0 for BEEP_OFF_MS, repeating;
//    on-phase starts at ALERT entry.
//      ack_q rise -> ACKED (priority over escalation on the same cycle).
//      alarm_q==0 -> IDLE (patient cleared locally).
//      ESCALATE_MS ticks elapsed -> ESCALATE.
//  - ESCALATE: alarm_led=1, buzzer=1 steady. pager_req set on entry.
//      ack_q rise -> ACKED. alarm_q==0 -> IDLE.
//  - ACKED: buzzer=0, alarm_led=0. Stays while alarm_q==1; alarm_q==0 -> IDLE.
//  - pager_req flag, independent of state:
//      set on ESCALATE entry; cleared on the edge after pack_q==1; else held.
//      Not cleared by caregiver ack or by return to IDLE; only by reset.
//      A new ESCALATE entry while still pending leaves it at 1 (no double page).
//  - caregiver_ack held high across an alarm rise is not an ack; a fresh rise is needed.
//  - Simultaneous alarm_q fall and ack_q rise: IDLE wins.
// TESTING (params TICKS_PER_MS=4, BEEP_ON_MS=2, BEEP_OFF_MS=1, ESCALATE_MS=10)
//  1 reset=0 with alarm=1 for 5 cycles -> buzzer/led/pager_req=0, event_count=0;
//    release -> ALERT two edges later, event_count=1.
//  2 alarm=1, no ack -> buzzer 8 cyc on / 4 cyc off from ALERT entry;
//    40 cyc later ESCALATE: buzzer steady 1, pager_req=1; pager_ack pulse ->
//    pager_req=0 two edges later.
//  3 ALERT, ack pulse at cycle 5 -> buzzer/led 0 two edges later, no pager_req;
//    alarm stays 1 -> ACKED held; alarm=0 -> IDLE.
//  4 alarm drops in ALERT -> IDLE; re-rise -> ALERT, event_count=2, cadence restarts on.
//  5 ack held high before alarm rise -> no ack; ack during ESCALATE with pager pending ->
//    ACKED, pager_req stays 1 until pager_ack.
//  6 256 alarm events -> event_count=255; reset mid-ESCALATE -> all outputs 0 next edge.

Source files
------------

// File: rtl/fall_alarm_annunciator.sv
// Nurse-station annunciator: latches fall alarms, drives LED/buzzer cadence,
// escalates unacknowledged alarms to the pager and counts alarm events.
module fall_alarm_annunciator #(
  parameter int TICKS_PER_MS = 1000,
  parameter int BEEP_ON_MS   = 500,
  parameter int BEEP_OFF_MS  = 500,
  parameter int ESCALATE_MS  = 60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm,
  input  logic       caregiver_ack,
  input  logic       pager_ack,
  output logic       buzzer,
  output logic       alarm_led,
  output logic       pager_req,
  output logic [7:0] event_count
);

  localparam int CYCLE_MS = BEEP_ON_MS + BEEP_OFF_MS;
  localparam int PW = $clog2(TICKS_PER_MS + 1);
  localparam int CW = $clog2(CYCLE_MS + 1);
  localparam int EW = $clog2(ESCALATE_MS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ALERT, S_ESCALATE, S_ACKED} state_t;

  state_t        state_reg, state_next;
  logic          alarm_q, alarm_qq, ack_q, ack_qq, pack_q;
  logic [PW-1:0] presc_reg, presc_next;
  logic [CW-1:0] phase_reg, phase_next;
  logic [EW-1:0] esc_reg, esc_next;
  logic [7:0]    count_reg, count_next;
  logic          pager_reg, pager_next;
  logic          buzzer_reg, buzzer_next;
  logic          led_reg, led_next;

  logic alarm_rise, ack_rise, tick;

  // Edges are taken on the registered copies so a level held across an
  // alarm rise never counts as a fresh acknowledge.
  assign alarm_rise = alarm_q & ~alarm_qq;
  assign ack_rise   = ack_q & ~ack_qq;
  assign tick       = (presc_reg == PW'(TICKS_PER_MS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      alarm_q    <= 1'b0;
      alarm_qq   <= 1'b0;
      ack_q      <= 1'b0;
      ack_qq     <= 1'b0;
      pack_q     <= 1'b0;
      presc_reg  <= '0;
      phase_reg  <= '0;
      esc_reg    <= '0;
      count_reg  <= '0;
      pager_reg  <= 1'b0;
      buzzer_reg <= 1'b0;
      led_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      alarm_q    <= alarm;
      alarm_qq   <= alarm_q;
      ack_q      <= caregiver_ack;
      ack_qq     <= ack_q;
      pack_q     <= pager_ack;
      presc_reg  <= presc_next;
      phase_reg  <= phase_next;
      esc_reg    <= esc_next;
      count_reg  <= count_next;
      pager_reg  <= pager_next;
      buzzer_reg <= buzzer_next;
      led_reg    <= led_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    phase_next = phase_reg;
    esc_next   = esc_reg;
    count_next = count_reg;
    // Pager request clears once the link accepts it; an escalation below overrides.
    pager_next = pack_q ? 1'b0 : pager_reg;

    case (state_reg)
      S_IDLE: begin
        if (alarm_rise) begin
          state_next = S_ALERT;
          presc_next = '0;
          phase_next = '0;
          esc_next   = '0;
          if (count_reg != 8'hFF) count_next = count_reg + 8'd1;
        end
      end
      S_ALERT: begin
        presc_next = tick ? '0 : presc_reg + PW'(1);
        if (tick) begin
          phase_next = (phase_reg == CW'(CYCLE_MS - 1)) ? '0 : phase_reg + CW'(1);
          esc_next   = esc_reg + EW'(1);
        end
        if (!alarm_q) begin
          state_next = S_IDLE;
        end else if (ack_rise) begin
          state_next = S_ACKED;
        end else if (tick && esc_reg == EW'(ESCALATE_MS - 1)) begin
          state_next = S_ESCALATE;
          pager_next = 1'b1;
        end
      end
      S_ESCALATE: begin
        if (!alarm_q)      state_next = S_IDLE;
        else if (ack_rise) state_next = S_ACKED;
      end
      S_ACKED: begin
        if (!alarm_q) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Outputs follow the state being entered so they change on the same edge.
    led_next    = (state_next == S_ALERT) || (state_next == S_ESCALATE);
    buzzer_next = (state_next == S_ESCALATE) ||
                  ((state_next == S_ALERT) && (phase_next < CW'(BEEP_ON_MS)));
  end

  assign buzzer      = buzzer_reg;
  assign alarm_led   = led_reg;
  assign pager_req   = pager_reg;
  assign event_count = count_reg;

endmodule

// File: tb/tb_fall_alarm_annunciator.sv
// Randomised scenario bench for fall_alarm_annunciator against a cycle-count
// reference model derived from elapsed time since ALERT entry.
module tb_fall_alarm_annunciator;

  localparam int T = 4, ON = 2, OFF = 1, ESC = 10;
  localparam int M_IDLE = 0, M_ALERT = 1, M_ESC = 2, M_ACK = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0, alarm = 1'b0, caregiver_ack = 1'b0, pager_ack = 1'b0;
  logic       buzzer, alarm_led, pager_req;
  logic [7:0] event_count;

  fall_alarm_annunciator #(
    .TICKS_PER_MS(T), .BEEP_ON_MS(ON), .BEEP_OFF_MS(OFF), .ESCALATE_MS(ESC)
  ) dut (
    .clk(clk), .reset(reset), .alarm(alarm), .caregiver_ack(caregiver_ack),
    .pager_ack(pager_ack), .buzzer(buzzer), .alarm_led(alarm_led),
    .pager_req(pager_req), .event_count(event_count)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Reference model: state plus the edge number at which ALERT was entered.
  int cyc = 0, m_state = M_IDLE, m_entry = 0, m_count = 0;
  bit m_pager = 0;
  bit aq = 0, aqq = 0, kq = 0, kqq = 0, pq = 0;

  function automatic logic [10:0] model_vec();
    bit b, l;
    int e;
    e = cyc - m_entry;
    l = (m_state == M_ALERT) || (m_state == M_ESC);
    b = (m_state == M_ESC) || ((m_state == M_ALERT) && (((e / T) % (ON + OFF)) < ON));
    return {b, l, m_pager, 8'(m_count)};
  endfunction

  // Drive inputs for one clock, advance the model across the edge, sample 1 unit later.
  task automatic apply(input bit rst_n, input bit al, input bit ck, input bit pk);
    bit arise, krise, setp;
    reset = rst_n; alarm = al; caregiver_ack = ck; pager_ack = pk;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_state = M_IDLE; m_count = 0; m_pager = 0;
      aq = 0; aqq = 0; kq = 0; kqq = 0; pq = 0;
    end else begin
      arise = aq & ~aqq;
      krise = kq & ~kqq;
      setp  = 0;
      case (m_state)
        M_IDLE:  if (arise) begin m_state = M_ALERT; m_entry = cyc; if (m_count < 255) m_count++; end
        M_ALERT: if (!aq) m_state = M_IDLE;
                 else if (krise) m_state = M_ACK;
                 else if (cyc - m_entry == ESC * T) begin m_state = M_ESC; setp = 1; end
        M_ESC:   if (!aq) m_state = M_IDLE; else if (krise) m_state = M_ACK;
        default: if (!aq) m_state = M_IDLE;
      endcase
      if (setp) m_pager = 1; else if (pq) m_pager = 0;
      aqq = aq; aq = al; kqq = kq; kq = ck; pq = pk;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 0);
      vectors++;
      if ({buzzer, alarm_led, pager_req, event_count} !== 11'h0) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got=%h want=000", cyc, {buzzer, alarm_led, pager_req, event_count});
      end
    end
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 0, 0);
      vectors++;
      if ({buzzer, alarm_led, pager_req, event_count} !== model_vec()) begin
        miscompares++;
        $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, {buzzer, alarm_led, pager_req, event_count}, model_vec());
      end
    end
    vectors++;
    if (event_count !== 8'd1 || alarm_led !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_event got count=%0d led=%b want count=1 led=1", event_count, alarm_led);
    end
    $display("reset scenario done at cycle %0d", cyc);
  endtask

  task automatic test_cadence_escalate();
    int pulse_at;
    pulse_at = 50 + $urandom_range(0, 10);
    apply(0, 0, 0, 0);
    for (int i = 0; i < pulse_at + 6; i++) begin
      apply(1, 1, 0, (i == pulse_at));
      vectors++;
      if ({buzzer, alarm_led, pager_req, event_count} !== model_vec()) begin
        miscompares++;
        $display("FAIL cadence cyc=%0d got=%h want=%h", cyc, {buzzer, alarm_led, pager_req, event_count}, model_vec());
      end
      if (i == pulse_at) begin
        vectors++;
        if (pager_req !== 1'b1 || buzzer !== 1'b1) begin
          miscompares++;
          $display("FAIL escalate_state got pager=%b buzzer=%b want 1 1", pager_req, buzzer);
        end
      end
    end
    vectors++;
    if (pager_req !== 1'b0) begin
      miscompares++;
      $display("FAIL pager_cleared got=%b want=0", pager_req);
    end
    $display("cadence/escalate scenario done, pager_ack at step %0d", pulse_at);
  endtask

  task automatic test_ack();
    int ack_at;
    ack_at = 5 + $urandom_range(0, 25);
    apply(0, 0, 0, 0);
    for (int i = 0; i < ack_at + 60; i++) begin
      apply(1, (i < ack_at + 55), (i == ack_at), 0);
      vectors++;
      if ({buzzer, alarm_led, pager_req, event_count} !== model_vec()) begin
        miscompares++;
        $display("FAIL ack cyc=%0d got=%h want=%h", cyc, {buzzer, alarm_led, pager_req, event_count}, model_vec());
      end
    end
    vectors++;
    if (pager_req !== 1'b0 || alarm_led !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_no_page got pager=%b led=%b want 0 0", pager_req, alarm_led);
    end
    $display("ack scenario done, ack at step %0d", ack_at);
  endtask

  task automatic test_realarm();
    int first_len;
    first_len = 3 + $urandom_range(0, 20);
    apply(0, 0, 0, 0);
    for (int i = 0; i < first_len + 20; i++) begin
      apply(1, !(i >= first_len && i < first_len + 3), 0, 0);
      vectors++;
      if ({buzzer, alarm_led, pager_req, event_count} !== model_vec()) begin
        miscompares++;
        $display("FAIL realarm cyc=%0d got=%h want=%h", cyc, {buzzer, alarm_led, pager_req, event_count}, model_vec());
      end
    end
    vectors++;
    if (event_count !== 8'd2) begin
      miscompares++;
      $display("FAIL realarm_count got=%0d want=2", event_count);
    end
    $display("re-alarm scenario done, first alarm %0d cycles", first_len);
  endtask

  task automatic test_held_ack();
    apply(0, 0, 1, 0);
    for (int i = 0; i < 70; i++) begin
      // ack held through the alarm rise and escalation, then released and re-pressed
      apply(1, 1, (i < 50) || (i == 55), (i == 66));
      vectors++;
      if ({buzzer, alarm_led, pager_req, event_count} !== model_vec()) begin
        miscompares++;
        $display("FAIL held_ack cyc=%0d got=%h want=%h", cyc, {buzzer, alarm_led, pager_req, event_count}, model_vec());
      end
      if (i == 60) begin
        vectors++;
        if (pager_req !== 1'b1 || alarm_led !== 1'b0) begin
          miscompares++;
          $display("FAIL acked_pager_pending got pager=%b led=%b want 1 0", pager_req, alarm_led);
        end
      end
    end
    $display("held-ack scenario done at cycle %0d", cyc);
  endtask

  task automatic test_saturate();
    apply(0, 0, 0, 0);
    for (int i = 0; i < 520; i++) begin
      apply(1, (i % 2 == 0), 0, 0);
      vectors++;
      if ({buzzer, alarm_led, pager_req, event_count} !== model_vec()) begin
        miscompares++;
        $display("FAIL saturate cyc=%0d got=%h want=%h", cyc, {buzzer, alarm_led, pager_req, event_count}, model_vec());
      end
    end
    vectors++;
    if (event_count !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate_count got=%0d want=255", event_count);
    end
    for (int i = 0; i < 48; i++) apply(1, 1, 0, 0);
    apply(0, 1, 0, 0);
    vectors++;
    if ({buzzer, alarm_led, pager_req, event_count} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset_mid_escalate got=%h want=000", {buzzer, alarm_led, pager_req, event_count});
    end
    $display("saturation scenario done at cycle %0d", cyc);
  endtask

  task automatic test_random();
    bit al;
    al = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) al = ~al;
      apply(($urandom_range(0, 299) != 0), al, ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0));
      vectors++;
      if ({buzzer, alarm_led, pager_req, event_count} !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, {buzzer, alarm_led, pager_req, event_count}, model_vec());
      end
    end
    $display("random scenario done at cycle %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_cadence_escalate();
    test_ack();
    test_realarm();
    test_held_ack();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
